// File: rtl/dbg_ctx_pkg.sv
// Shared types and helpers for the debug context sequencer.
//   state_e  : sequencer FSM states
//   op_e     : command opcode (SAVE / RESTORE)
//   gpr_addr : debug address of GPR x<idx> relative to a base address
package dbg_ctx_pkg;

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] GPR_BASE_DEF = 15'h400;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HALT,
    S_XFER_REQ,
    S_XFER_WAIT,
    S_VERIFY_REQ,
    S_VERIFY_WAIT,
    S_RESUME,
    S_DONE,
    S_ABORT
  } state_e;

  typedef enum logic {
    OP_SAVE    = 1'b0,
    OP_RESTORE = 1'b1
  } op_e;

  // xi lives at base + 4*i
  function automatic logic [ADDR_W-1:0] gpr_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/dbg_ctx_buffer.sv
// Context buffer: NUM_REGS x 32-bit register file, cleared by reset.
//   clk, rst_n       : clock, async active-low reset
//   we/waddr/wdata   : single write port (host or sequencer, muxed by the parent)
//   raddr_a/rdata_a  : combinational read port A (host)
//   raddr_b/rdata_b  : combinational read port B (sequencer write data / compare)
module dbg_ctx_buffer
  import dbg_ctx_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dbg_ctx_sequencer.sv
// Debug context sequencer: halts the core, saves GPRs into the local buffer
// (SAVE) or writes them back from it (RESTORE), then resumes or stays halted.
//   cmd_*          : command handshake (valid/ready, op, stay_halted)
//   done/err/busy  : completion pulse, abort/verify-error pulse, busy status
//   buf_*          : host access to the context buffer (writes only in IDLE)
//   debug_*        : SoC debug port (request/grant/response, halt/resume/halted)
//   mismatch_idx_o : first mismatching index of the verify pass
// Optional build macro DBG_CTX_VERIFY_EN adds a read-back verify pass after
// RESTORE and the mismatch_idx_o port.
module dbg_ctx_sequencer
  import dbg_ctx_pkg::*;
#(
  parameter int unsigned       NUM_REGS       = 32,
  parameter logic [ADDR_W-1:0] GPR_BASE       = GPR_BASE_DEF,
  parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_op_i,
  input  logic              cmd_stay_halted_i,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o,
  input  logic              buf_we_i,
  input  logic [IDX_W-1:0]  buf_idx_i,
  input  logic [DATA_W-1:0] buf_wdata_i,
  output logic [DATA_W-1:0] buf_rdata_o,
  output logic              debug_req_o,
  output logic              debug_we_o,
  output logic [ADDR_W-1:0] debug_addr_o,
  output logic [DATA_W-1:0] debug_wdata_o,
  output logic              debug_halt_o,
  output logic              debug_resume_o,
  input  logic              debug_gnt_i,
  input  logic              debug_rvalid_i,
  input  logic [DATA_W-1:0] debug_rdata_i,
  input  logic              debug_halted_i
`ifdef DBG_CTX_VERIFY_EN
  ,
  output logic [IDX_W-1:0]  mismatch_idx_o
`endif
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state, state_next, post_run, post_xfer;
  op_e               op;
  logic              stay;
  logic [IDX_W-1:0]  idx;
  logic [TMR_W-1:0]  timer;
  logic              tmo, last, accept, capture, host_we, err_done;
  logic              buf_we;
  logic [IDX_W-1:0]  buf_waddr;
  logic [DATA_W-1:0] buf_wdata, seq_rdata;

  assign accept  = (state == S_IDLE) && cmd_valid_i;
  assign last    = (idx == IDX_W'(NUM_REGS - 1));
  assign tmo     = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign capture = (state == S_XFER_WAIT) && debug_rvalid_i && (op == OP_SAVE);
  assign host_we = (state == S_IDLE) && buf_we_i;

  assign buf_we    = capture || host_we;
  assign buf_waddr = capture ? idx : buf_idx_i;
  assign buf_wdata = capture ? debug_rdata_i : buf_wdata_i;

  dbg_ctx_buffer #(.NUM_REGS(NUM_REGS)) u_buf (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .we      (buf_we),
    .waddr   (buf_waddr),
    .wdata   (buf_wdata),
    .raddr_a (buf_idx_i),
    .rdata_a (buf_rdata_o),
    .raddr_b (idx),
    .rdata_b (seq_rdata)
  );

  assign post_run = stay ? S_DONE : S_RESUME;

`ifdef DBG_CTX_VERIFY_EN
  logic             mism_flag;
  logic [IDX_W-1:0] mism_idx;

  assign post_xfer = (op == OP_RESTORE) ? S_VERIFY_REQ : post_run;
  assign err_done  = mism_flag;
  assign mismatch_idx_o = mism_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mism_flag <= 1'b0;
      mism_idx  <= '0;
    end else if (accept) begin
      mism_flag <= 1'b0;
      mism_idx  <= '0;
    end else if ((state == S_VERIFY_WAIT) && debug_rvalid_i && !mism_flag &&
                 (debug_rdata_i != seq_rdata)) begin
      mism_flag <= 1'b1;
      mism_idx  <= idx;
    end
  end
`else
  assign post_xfer = post_run;
  assign err_done  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_next;
  end

  // Index, per-state timer and latched command
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx   <= '0;
      timer <= '0;
      op    <= OP_SAVE;
      stay  <= 1'b0;
    end else begin
      if ((state_next != state) || (state == S_IDLE)) timer <= '0;
      else                                            timer <= timer + 1'b1;

      if (accept) begin
        op   <= op_e'(cmd_op_i);
        stay <= cmd_stay_halted_i;
        idx  <= cmd_op_i ? IDX_W'(1) : '0;
      end else if ((state == S_XFER_WAIT) && debug_rvalid_i) begin
        // wrap to x1: the verify pass (if any) starts there
        idx <= last ? IDX_W'(1) : idx + 1'b1;
      end else if ((state == S_VERIFY_WAIT) && debug_rvalid_i && !last) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:        if (cmd_valid_i) state_next = debug_halted_i ? S_XFER_REQ : S_HALT;
      S_HALT:        if (debug_halted_i)      state_next = S_XFER_REQ;
                     else if (tmo)            state_next = S_ABORT;
      S_XFER_REQ:    if (debug_gnt_i)         state_next = S_XFER_WAIT;
                     else if (tmo)            state_next = S_ABORT;
      S_XFER_WAIT:   if (debug_rvalid_i)      state_next = last ? post_xfer : S_XFER_REQ;
                     else if (tmo)            state_next = S_ABORT;
      S_VERIFY_REQ:  if (debug_gnt_i)         state_next = S_VERIFY_WAIT;
                     else if (tmo)            state_next = S_ABORT;
      S_VERIFY_WAIT: if (debug_rvalid_i)      state_next = last ? post_run : S_VERIFY_REQ;
                     else if (tmo)            state_next = S_ABORT;
      S_RESUME:      if (!debug_halted_i)     state_next = S_DONE;
                     else if (tmo)            state_next = S_ABORT;
      S_DONE:                                 state_next = S_IDLE;
      S_ABORT:                                state_next = S_IDLE;
      default:                                state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cmd_ready_o    = 1'b0;
    busy_o         = 1'b1;
    done_o         = 1'b0;
    err_o          = 1'b0;
    debug_req_o    = 1'b0;
    debug_we_o     = 1'b0;
    debug_addr_o   = '0;
    debug_wdata_o  = '0;
    debug_halt_o   = 1'b0;
    debug_resume_o = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_HALT:   debug_halt_o = 1'b1;
      S_XFER_REQ: begin
        debug_req_o   = 1'b1;
        debug_we_o    = (op == OP_RESTORE);
        debug_addr_o  = gpr_addr(GPR_BASE, idx);
        debug_wdata_o = seq_rdata;
      end
      S_VERIFY_REQ: begin
        debug_req_o  = 1'b1;
        debug_addr_o = gpr_addr(GPR_BASE, idx);
      end
      S_RESUME: debug_resume_o = 1'b1;
      S_DONE: begin
        done_o = 1'b1;
        err_o  = err_done;
      end
      S_ABORT: begin
        done_o = 1'b1;
        err_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
